// File: rtl/mips_alu_muldiv.sv
// MIPS ALU with single-cycle ops and iterative HI/LO multiply/divide.
// Define MIPS_ALU_DIV_EN to include the restoring divider.
module mips_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_field,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
    OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  } op_t;

  state_t           state;
  op_t              op;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] acc, mq, opnd;
  logic             neg_q;
  logic [WIDTH-1:0] alu_res;
  logic             go_mul, go_div, sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] nxt_acc, nxt_mq;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign in_ready = (state == IDLE);

  always_comb begin
    op = OP_ADD;
    if (opcode == 6'h00) begin
      case (func_field)
        6'h20:   op = OP_ADD;
        6'h22:   op = OP_SUB;
        6'h24:   op = OP_AND;
        6'h25:   op = OP_OR;
        6'h27:   op = OP_NOR;
        6'h2A:   op = OP_SLT;
        6'h2B:   op = OP_SLTU;
        6'h10:   op = OP_MFHI;
        6'h12:   op = OP_MFLO;
        6'h18:   op = OP_MULT;
        6'h19:   op = OP_MULTU;
        6'h1A:   op = OP_DIV;
        6'h1B:   op = OP_DIVU;
        default: op = OP_ADD;
      endcase
    end else if (opcode == 6'h04) begin
      op = OP_SUB;
    end
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // Signed ops run on magnitudes; signs are reapplied on completion.
  assign go_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg  = sgn & A[WIDTH-1];
  assign b_neg  = sgn & B[WIDTH-1];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;

  assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
  assign prod    = {mul_sum[WIDTH:1], mul_sum[0], mq[WIDTH-1:1]};
  assign prod_s  = neg_q ? -prod : prod;

`ifdef MIPS_ALU_DIV_EN
  logic             is_div, neg_r;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] div_acc, div_mq;

  assign go_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign shifted = {acc, mq[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd};
  assign ge      = shifted >= {1'b0, opnd};
  assign div_acc = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign div_mq  = {mq[WIDTH-2:0], ge};
  assign nxt_acc = is_div ? div_acc : prod[2*WIDTH-1:WIDTH];
  assign nxt_mq  = is_div ? div_mq : prod[WIDTH-1:0];
  assign fin_hi  = is_div ? (neg_r ? -div_acc : div_acc)
                          : prod_s[2*WIDTH-1:WIDTH];
  assign fin_lo  = is_div ? (neg_q ? -div_mq : div_mq)
                          : prod_s[WIDTH-1:0];
`else
  assign go_div  = 1'b0;
  assign nxt_acc = prod[2*WIDTH-1:WIDTH];
  assign nxt_mq  = prod[WIDTH-1:0];
  assign fin_hi  = prod_s[2*WIDTH-1:WIDTH];
  assign fin_lo  = prod_s[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      acc       <= '0;
      mq        <= '0;
      opnd      <= '0;
      neg_q     <= 1'b0;
`ifdef MIPS_ALU_DIV_EN
      is_div    <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      zero      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt <= '0;
            if (go_mul) begin
              acc   <= '0;
              mq    <= b_mag;
              opnd  <= a_mag;
              neg_q <= a_neg ^ b_neg;
`ifdef MIPS_ALU_DIV_EN
              is_div <= 1'b0;
`endif
              state <= BUSY;
            end else if (go_div && B == '0) begin
              lo        <= '1;
              hi        <= A;
              result    <= '1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (go_div) begin
              acc   <= '0;
              mq    <= a_mag;
              opnd  <= b_mag;
              neg_q <= a_neg ^ b_neg;
`ifdef MIPS_ALU_DIV_EN
              is_div <= 1'b1;
              neg_r  <= a_neg;
`endif
              state <= BUSY;
            end else begin
              result    <= alu_res;
              out_valid <= 1'b1;
              zero      <= (alu_res == '0);
            end
          end
        end
        BUSY: begin
          acc <= nxt_acc;
          mq  <= nxt_mq;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi        <= fin_hi;
            lo        <= fin_lo;
            result    <= fin_lo;
            out_valid <= 1'b1;
            zero      <= (fin_lo == '0);
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Directed self-checking bench for mips_alu_muldiv.
// Covers WIDTH=32 and WIDTH=8 instances side by side.
module tb_mips_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [5:0]  func_field = '0;
  logic [31:0] A = '0, B = '0;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;

  logic        v8 = 1'b0;
  logic        rdy8;
  logic [5:0]  op8 = '0, fn8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ov8;
  logic [7:0]  res8;
  logic        z8;

  int checks = 0;
  int errors = 0;
  int lat, busy, cnt;

  always #5 clk = ~clk;

  mips_alu_muldiv #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready), .opcode(opcode),
    .func_field(func_field), .A(A), .B(B),
    .out_valid(out_valid), .result(result), .zero(zero)
  );

  mips_alu_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8),
    .in_ready(rdy8), .opcode(op8),
    .func_field(fn8), .A(a8), .B(b8),
    .out_valid(ov8), .result(res8), .zero(z8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op and wait for its out_valid (bounded).
  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input logic [31:0] a, input logic [31:0] b,
                     output int l, output int bz);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    opcode = op; func_field = fn; A = a; B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 1; bz = 0;
    while (!out_valid && l < 100) begin
      if (!in_ready) bz++;
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic single(input string tag,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic ez);
    int l, bz;
    run(op, fn, a, b, l, bz);
    chk({tag, "_lat"}, 64'(l), 64'd1);
    chk({tag, "_res"}, 64'(result), 64'(exp));
    chk({tag, "_zero"}, 64'(zero), 64'(ez));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    rst_n = 1'b1;
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Back-to-back ADD then SLT
    opcode = 6'h00; func_field = 6'h20; A = 32'd7; B = 32'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_v0", 64'(out_valid), 64'd1);
    chk("b2b_r0", 64'(result), 64'd12);
    chk("b2b_z0", 64'(zero), 64'd0);
    chk("b2b_rdy", 64'(in_ready), 64'd1);
    func_field = 6'h2A; A = 32'hFFFF_FFFF; B = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_v1", 64'(out_valid), 64'd1);
    chk("b2b_r1", 64'(result), 64'd1);
    chk("b2b_z1", 64'(zero), 64'd0);
    @(posedge clk); #1;
    chk("hold_v", 64'(out_valid), 64'd0);
    chk("hold_r", 64'(result), 64'd1);

    single("sltu", 6'h00, 6'h2B, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    single("and", 6'h00, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
           32'h00F0_00F0, 1'b0);
    single("or", 6'h00, 6'h25, 32'hF000_0000, 32'h0000_000F,
           32'hF000_000F, 1'b0);
    single("nor", 6'h00, 6'h27, 32'hFFFF_0000, 32'h0000_FFFF,
           32'd0, 1'b1);
    single("lw", 6'h23, 6'h3F, 32'h1000, 32'h24, 32'h1024, 1'b0);
    single("sw_wrap", 6'h2B, 6'h00, 32'hFFFF_FFFF, 32'd1,
           32'd0, 1'b1);
    single("unk_op", 6'h08, 6'h22, 32'd3, 32'd4, 32'd7, 1'b0);
    single("unk_fn", 6'h00, 6'h21, 32'd10, 32'd20, 32'd30, 1'b0);
    single("beq", 6'h04, 6'h00, 32'h1234, 32'h1234, 32'd0, 1'b1);
    @(posedge clk); #1;
    chk("zero_gate", 64'(zero), 64'd0);
    chk("zero_hold_r", 64'(result), 64'd0);
    single("sub", 6'h00, 6'h22, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);

    // Signed multiply -3 * 5
    run(6'h00, 6'h18, 32'hFFFF_FFFD, 32'd5, lat, busy);
    chk("mult_lat", 64'(lat), 64'd33);
    chk("mult_busy", 64'(busy), 64'd32);
    chk("mult_lo", 64'(result), 64'hFFFF_FFF1);
    single("mfhi", 6'h00, 6'h10, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    single("mflo", 6'h00, 6'h12, 32'd0, 32'd0, 32'hFFFF_FFF1, 1'b0);

`ifdef MIPS_ALU_DIV_EN
    run(6'h00, 6'h1A, 32'hFFFF_FFF9, 32'd2, lat, busy);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_lo", 64'(result), 64'hFFFF_FFFD);
    single("div_hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run(6'h00, 6'h1A, 32'd7, 32'hFFFF_FFFE, lat, busy);
    chk("div_neg_lo", 64'(result), 64'hFFFF_FFFD);
    single("div_neg_hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'd1, 1'b0);
    run(6'h00, 6'h1B, 32'd100, 32'd7, lat, busy);
    chk("divu_lo", 64'(result), 64'd14);
    single("divu_hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'd2, 1'b0);
    run(6'h00, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy);
    chk("divmin_lo", 64'(result), 64'h8000_0000);
    single("divmin_hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 1'b1);
    run(6'h00, 6'h1A, 32'h55, 32'd0, lat, busy);
    chk("div0_lat", 64'(lat), 64'd1);
    chk("div0_lo", 64'(result), 64'hFFFF_FFFF);
    single("div0_hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'h55, 1'b0);
`else
    single("div_off", 6'h00, 6'h1A, 32'd100, 32'd7, 32'd0, 1'b1);
    single("divu_off", 6'h00, 6'h1B, 32'd9, 32'd0, 32'd0, 1'b1);
    single("off_hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    single("off_lo", 6'h00, 6'h12, 32'd0, 32'd0, 32'hFFFF_FFF1, 1'b0);
`endif

    run(6'h00, 6'h18, 32'h8000_0000, 32'h8000_0000, lat, busy);
    chk("mmin_lo", 64'(result), 64'd0);
    chk("mmin_z", 64'(zero), 64'd1);
    single("mmin_hi", 6'h00, 6'h10, 32'd0, 32'd0, 32'h4000_0000, 1'b0);
    run(6'h00, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_lo", 64'(result), 64'd1);

    // Reset in the middle of a MULTU
    opcode = 6'h00; func_field = 6'h19; A = 32'd5; B = 32'd6;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    repeat (9) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_res", 64'(result), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    chk("mrst_ready", 64'(in_ready), 64'd1);
    repeat (40) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("mrst_no_valid", 64'(cnt), 64'd0);
    single("mrst_mflo", 6'h00, 6'h12, 32'd0, 32'd0, 32'd0, 1'b1);
    single("mrst_mfhi", 6'h00, 6'h10, 32'd0, 32'd0, 32'd0, 1'b1);

    // 8-bit MULTU FF * FF
    op8 = 6'h00; fn8 = 6'h19; a8 = 8'hFF; b8 = 8'hFF;
    v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("w8_lat", 64'(lat), 64'd9);
    chk("w8_lo", 64'(res8), 64'h01);
    chk("w8_z", 64'(z8), 64'd0);
    @(posedge clk); #1;
    fn8 = 6'h10;
    v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    chk("w8_hi_v", 64'(ov8), 64'd1);
    chk("w8_hi", 64'(res8), 64'hFE);
    chk("w8_rdy", 64'(rdy8), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
